dmem_ctrl: RTL and testbench
============================

// Module: dmem_ctrl
// PURPOSE
//  Memory-stage responder for the pipeline controller's M-stage outputs (memwriteM, memtoregM).
//  Converts each lw/sw into a req/ack transaction on a variable-latency data-memory bus.
//  Holds the pipeline through stallM until the access completes, then presents load data to the W-stage register.
//  Flags misaligned addresses and bus timeouts.
// PARAMETERS
//  AW       32  address width (aluoutM / mem_addr)
//  DW       32  data width
//  TIMEOUT  15  max BUSY cycles without mem_ack before abort (>=1)
// PORTS
//  clk          in   1   system clock, rising edge
//  rst          in   1   reset, asynchronous, active-low (0 = reset)
//  memwriteM    in   1   M-stage store request
//  memtoregM    in   1   M-stage load request
//  aluoutM      in   AW  byte address
//  writedataM   in   DW  store data
//  stallM       out  1   freeze F/D/E/M registers while high
//  readdataM    out  DW  load data to W-stage register
//  err_align    out  1   1-cycle pulse: addr[1:0]!=0, access dropped
//  err_timeout  out  1   1-cycle pulse: TIMEOUT reached, access aborted
//  mem_req      out  1   bus request
//  mem_we       out  1   1 = write, 0 = read
//  mem_addr     out  AW  word-aligned bus address
//  mem_wdata    out  DW  bus write data
//  mem_rdata    in   DW  bus read data, valid with mem_ack
//  mem_ack      in   1   1-cycle completion strobe
// BEHAVIOUR
//  Reset (rst=0, async): state=IDLE; mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0,
//    rdata_q=0, cnt=0, err_*=0. stallM=0 while in reset.
//  access = memwriteM|memtoregM. If both are high, it is treated as a write.
//  FSM states: IDLE, BUSY, DONE.
//  IDLE, access, aligned: latch we/addr/wdata; go to BUSY; mem_req=1 from the next cycle; stallM=1 this cycle (comb).
//  IDLE, access, misaligned: no bus cycle; err_align=1 this cycle (comb); stallM=0; readdataM=0; stay in IDLE.
//  IDLE, no access: stallM=0; mem_ack ignored.
//  BUSY: mem_req=1; we/addr/wdata stable; stallM=1; cnt increments each cycle.
//    mem_ack=1: rdata_q<=mem_rdata (reads only); mem_req<=0; go to DONE.
//    cnt==TIMEOUT-1 and no ack: rdata_q<=0; err_timeout pulses in DONE; mem_req<=0; go to DONE.
//    ack and timeout in the same cycle: ack wins, no error.
//  DONE: stallM=0; readdataM=rdata_q; the pipeline advances on this edge; go to IDLE.
//    No new access is accepted in DONE, because the same instruction is still in M.
//  readdataM = rdata_q in DONE, 0 otherwise. A store leaves rdata_q unchanged.
//  Latency: aligned access with ack k cycles after req rises -> stallM high k+1 cycles.
//    Minimum: ack in the first BUSY cycle -> 2 stall cycles.
//  cnt is clog2(TIMEOUT+1) bits wide, cleared on entering BUSY, saturating.
//  Async reset mid-BUSY drops mem_req immediately. The bus must tolerate an abandoned request.
//  mem_ack outside BUSY: ignored, no state change.
// STRUCTURE
//  Shared header defines.vh: state encodings DMEM_IDLE=2'd0, DMEM_BUSY=2'd1, DMEM_DONE=2'd2;
//    TIMEOUT default value.
//  One sub-module: dmem_timeout_cnt (cnt, clear, enable, expired).
//  FSM, request latches and rdata_q live in dmem_ctrl.
// TESTING
//  1 Load addr 0x100, ack 1 cycle after req, rdata 0xCAFEF00D
//    -> stallM high 2 cycles; readdataM=0xCAFEF00D in DONE.
//  2 Store addr 0x204, wdata 0x12345678, ack after 4 cycles
//    -> mem_we=1; addr and wdata stable while req=1; stallM high 5 cycles.
//  3 Load addr 0x102 -> err_align 1 cycle; mem_req never rises; stallM=0; readdataM=0.
//  4 Load, no ack, TIMEOUT=15 -> req high 15 cycles; err_timeout pulse in DONE; readdataM=0.
//  5 Ack coincident with the last timeout cycle -> no err_timeout; data captured.
//  6 rst=0 in the 2nd BUSY cycle -> mem_req=0 and stallM=0 immediately; next access starts cleanly.

Source files
------------

// File: rtl/dmem_ctrl_pkg.sv
// ============================================================================
// dmem_ctrl_pkg : shared state encodings and sizing helpers for dmem_ctrl
// Revision 1.0
// ============================================================================
`default_nettype none

package dmem_ctrl_pkg;

    typedef enum logic [1:0] {
        DMEM_IDLE = 2'd0,
        DMEM_BUSY = 2'd1,
        DMEM_DONE = 2'd2
    } dmem_state_e;

    localparam int DMEM_TIMEOUT_DEF = 15;

    // Counter must be able to represent TIMEOUT itself so it can saturate there.
    function automatic int dmem_cnt_width(input int timeout);
        return $clog2(timeout + 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/dmem_timeout_cnt.sv
// ============================================================================
// dmem_timeout_cnt : saturating BUSY-cycle counter with expiry flag
// Revision 1.0
// ============================================================================
`default_nettype none

module dmem_timeout_cnt
    import dmem_ctrl_pkg::*;
#(
    parameter int TIMEOUT = DMEM_TIMEOUT_DEF
)
(
    input  logic clk,
    input  logic rst,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);

    localparam int             CNT_W  = dmem_cnt_width(TIMEOUT);
    localparam logic [CNT_W-1:0] c_last = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] c_sat  = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] c_one  = CNT_W'(1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (enable_i && (cnt_q != c_sat)) begin
            cnt_d = cnt_q + c_one;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Expiry marks the final BUSY cycle, so the FSM can abort on that edge.
    assign expired_o = (cnt_q == c_last);

endmodule

`default_nettype wire

// File: rtl/dmem_ctrl.sv
// ============================================================================
// dmem_ctrl : M-stage load/store to req/ack data-memory bus bridge with stall
// Revision 1.0
// ============================================================================
`default_nettype none

module dmem_ctrl
    import dmem_ctrl_pkg::*;
#(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = DMEM_TIMEOUT_DEF
)
(
    input  logic          clk,
    input  logic          rst,
    input  logic          memwriteM,
    input  logic          memtoregM,
    input  logic [AW-1:0] aluoutM,
    input  logic [DW-1:0] writedataM,
    output logic          stallM,
    output logic [DW-1:0] readdataM,
    output logic          err_align,
    output logic          err_timeout,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_ack
);

    dmem_state_e   state_q, state_d;
    logic          req_q, req_d;
    logic          we_q, we_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [DW-1:0] rdata_q, rdata_d;
    logic          errto_q, errto_d;

    logic          w_access;
    logic          w_misaligned;
    logic          w_stall;
    logic          w_err_align;
    logic          w_cnt_clear;
    logic          w_cnt_en;
    logic          w_expired;

    assign w_access     = memwriteM | memtoregM;
    assign w_misaligned = (aluoutM[1:0] != 2'b00);

    dmem_timeout_cnt #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout_cnt (
        .clk       (clk),
        .rst       (rst),
        .clear_i   (w_cnt_clear),
        .enable_i  (w_cnt_en),
        .expired_o (w_expired)
    );

    always_comb begin
        state_d     = state_q;
        req_d       = req_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rdata_d     = rdata_q;
        errto_d     = 1'b0;
        w_stall     = 1'b0;
        w_err_align = 1'b0;
        w_cnt_clear = 1'b0;
        w_cnt_en    = 1'b0;

        case (state_q)
            DMEM_IDLE: begin
                if (w_access) begin
                    if (w_misaligned) begin
                        w_err_align = 1'b1;
                    end else begin
                        w_stall     = 1'b1;
                        w_cnt_clear = 1'b1;
                        req_d       = 1'b1;
                        we_d        = memwriteM;
                        addr_d      = {aluoutM[AW-1:2], 2'b00};
                        wdata_d     = writedataM;
                        state_d     = DMEM_BUSY;
                    end
                end
            end
            DMEM_BUSY: begin
                w_stall  = 1'b1;
                w_cnt_en = 1'b1;
                // An ack on the expiry cycle still completes the access cleanly.
                if (mem_ack) begin
                    if (!we_q) begin
                        rdata_d = mem_rdata;
                    end
                    req_d   = 1'b0;
                    state_d = DMEM_DONE;
                end else if (w_expired) begin
                    rdata_d = '0;
                    errto_d = 1'b1;
                    req_d   = 1'b0;
                    state_d = DMEM_DONE;
                end
            end
            DMEM_DONE: begin
                state_d = DMEM_IDLE;
            end
            default: begin
                req_d   = 1'b0;
                state_d = DMEM_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= DMEM_IDLE;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            errto_q <= 1'b0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            errto_q <= errto_d;
        end
    end

    // Combinational flags are masked so nothing escapes while reset is held.
    assign stallM      = w_stall & rst;
    assign err_align   = w_err_align & rst;
    assign err_timeout = errto_q;
    assign readdataM   = (state_q == DMEM_DONE) ? rdata_q : '0;
    assign mem_req     = req_q;
    assign mem_we      = we_q;
    assign mem_addr    = addr_q;
    assign mem_wdata   = wdata_q;

endmodule

`default_nettype wire

// File: tb/tb_dmem_ctrl.sv
// ============================================================================
// tb_dmem_ctrl : randomized instruction stream against a transaction model
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_dmem_ctrl;

    localparam int TO = 15;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        memwriteM = 1'b0;
    logic        memtoregM = 1'b0;
    logic [31:0] aluoutM = '0;
    logic [31:0] writedataM = '0;
    logic        stallM;
    logic [31:0] readdataM;
    logic        err_align;
    logic        err_timeout;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = '0;
    logic        mem_ack = 1'b0;

    always #5 clk = ~clk;

    dmem_ctrl #(
        .AW      (32),
        .DW      (32),
        .TIMEOUT (TO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .memwriteM   (memwriteM),
        .memtoregM   (memtoregM),
        .aluoutM     (aluoutM),
        .writedataM  (writedataM),
        .stallM      (stallM),
        .readdataM   (readdataM),
        .err_align   (err_align),
        .err_timeout (err_timeout),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata),
        .mem_ack     (mem_ack)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Per-cycle expectations published by the driver
    logic        exp_valid = 1'b0;
    logic        e_stall, e_req, e_we, e_ea, e_et;
    logic [31:0] e_addr, e_wdata, e_rd;

    // Per-instruction observations of the DUT
    int          obs_stall, obs_req, obs_et, obs_ea;
    logic [31:0] obs_rd;

    // Architectural load-data register as seen at the W stage
    logic [31:0] reg_m = '0;

    always @(negedge clk) begin
        if (exp_valid) begin
            check("stallM", {31'b0, stallM}, {31'b0, e_stall});
            check("mem_req", {31'b0, mem_req}, {31'b0, e_req});
            if (e_req) begin
                check("mem_we", {31'b0, mem_we}, {31'b0, e_we});
                check("mem_addr", mem_addr, e_addr);
                check("mem_wdata", mem_wdata, e_wdata);
            end
            check("readdataM", readdataM, e_rd);
            check("err_align", {31'b0, err_align}, {31'b0, e_ea});
            check("err_timeout", {31'b0, err_timeout}, {31'b0, e_et});
            if (stallM) obs_stall++;
            if (mem_req) obs_req++;
            if (err_timeout) obs_et++;
            if (err_align) obs_ea++;
            obs_rd = readdataM;
        end
    end

    // One M-stage instruction; ackn = BUSY cycle carrying mem_ack (>TO means never).
    task automatic run_instr(input logic wr, input logic rd, input logic [31:0] addr,
                             input logic [31:0] wdata, input logic [31:0] rdata,
                             input int ackn, input bit spur);
        logic        access, mis, tmo;
        logic [31:0] done_rd;
        int          len, busy;
        access = wr | rd;
        mis    = (addr[1:0] != 2'b00);
        tmo    = 1'b0;
        busy   = 0;
        if (!access || mis) begin
            len = 1;
        end else begin
            if (ackn >= 1 && ackn <= TO) busy = ackn;
            else begin busy = TO; tmo = 1'b1; end
            len = busy + 2;
        end
        if (tmo) done_rd = '0;
        else if (!wr) done_rd = rdata;
        else done_rd = reg_m;
        obs_stall = 0; obs_req = 0; obs_et = 0; obs_ea = 0; obs_rd = '0;
        for (int c = 0; c < len; c++) begin
            @(posedge clk);
            #1;
            memwriteM  = wr;
            memtoregM  = rd;
            aluoutM    = addr;
            writedataM = wdata;
            if (len > 1 && c == ackn) begin
                mem_ack   = 1'b1;
                mem_rdata = rdata;
            end else begin
                mem_ack   = (spur && (c == 0 || c == len - 1)) ? 1'($urandom % 2) : 1'b0;
                mem_rdata = $urandom;
            end
            e_stall = (len > 1) && (c < len - 1);
            e_req   = (len > 1) && (c >= 1) && (c <= busy);
            e_we    = wr;
            e_addr  = {addr[31:2], 2'b00};
            e_wdata = wdata;
            e_ea    = access && mis;
            e_et    = (len > 1) && (c == len - 1) && tmo;
            e_rd    = ((len > 1) && (c == len - 1)) ? done_rd : 32'h0;
            exp_valid = 1'b1;
        end
        @(negedge clk);
        #1;
        exp_valid = 1'b0;
        mem_ack   = 1'b0;
        if (len > 1) reg_m = done_rd;
    endtask

    initial begin
        // Reset state, with a pending access that must not leak through
        memtoregM = 1'b1;
        aluoutM   = 32'h100;
        @(negedge clk);
        #1;
        check("rst_stallM", {31'b0, stallM}, 32'h0);
        check("rst_mem_req", {31'b0, mem_req}, 32'h0);
        check("rst_mem_we", {31'b0, mem_we}, 32'h0);
        check("rst_mem_addr", mem_addr, 32'h0);
        check("rst_mem_wdata", mem_wdata, 32'h0);
        check("rst_readdataM", readdataM, 32'h0);
        check("rst_err_timeout", {31'b0, err_timeout}, 32'h0);
        aluoutM = 32'h101;
        #1;
        check("rst_err_align", {31'b0, err_align}, 32'h0);
        memtoregM = 1'b0;
        aluoutM   = '0;
        #1;
        rst = 1'b1;

        // 1: load, ack in first BUSY cycle
        run_instr(1'b0, 1'b1, 32'h100, 32'h0, 32'hCAFEF00D, 1, 1'b0);
        check("t1_stall_cycles", obs_stall, 32'd2);
        check("t1_readdata", obs_rd, 32'hCAFEF00D);
        // 2: store, ack on 4th BUSY cycle; load register unchanged
        run_instr(1'b1, 1'b0, 32'h204, 32'h12345678, 32'hDEADBEEF, 4, 1'b0);
        check("t2_stall_cycles", obs_stall, 32'd5);
        check("t2_req_cycles", obs_req, 32'd4);
        check("t2_readdata", obs_rd, 32'hCAFEF00D);
        // 3: misaligned load
        run_instr(1'b0, 1'b1, 32'h102, 32'h0, 32'h11111111, 1, 1'b0);
        check("t3_err_align", obs_ea, 32'd1);
        check("t3_req_cycles", obs_req, 32'd0);
        check("t3_stall_cycles", obs_stall, 32'd0);
        // 4: load with no ack
        run_instr(1'b0, 1'b1, 32'h300, 32'h0, 32'h22222222, 99, 1'b0);
        check("t4_req_cycles", obs_req, 32'd15);
        check("t4_err_timeout", obs_et, 32'd1);
        check("t4_readdata", obs_rd, 32'h0);
        check("t4_stall_cycles", obs_stall, 32'd16);
        // 5: ack on the last timeout cycle
        run_instr(1'b0, 1'b1, 32'h304, 32'h0, 32'h5A5A1234, TO, 1'b0);
        check("t5_err_timeout", obs_et, 32'd0);
        check("t5_readdata", obs_rd, 32'h5A5A1234);
        check("t5_stall_cycles", obs_stall, 32'd16);

        // 6: asynchronous reset in the 2nd BUSY cycle
        @(posedge clk);
        #1;
        memtoregM = 1'b1;
        aluoutM   = 32'h400;
        @(posedge clk);
        @(posedge clk);
        #3;
        check("t6_req_before", {31'b0, mem_req}, 32'h1);
        check("t6_stall_before", {31'b0, stallM}, 32'h1);
        rst = 1'b0;
        #1;
        check("t6_req_after", {31'b0, mem_req}, 32'h0);
        check("t6_stall_after", {31'b0, stallM}, 32'h0);
        memtoregM = 1'b0;
        aluoutM   = '0;
        @(negedge clk);
        #1;
        rst   = 1'b1;
        reg_m = '0;
        // Store right after reset exposes the cleared load register in DONE
        run_instr(1'b1, 1'b0, 32'h500, 32'hA5A5A5A5, 32'h0, 2, 1'b0);
        check("t6_post_stall", obs_stall, 32'd3);
        check("t6_post_readdata", obs_rd, 32'h0);

        // Randomized instruction stream
        for (int i = 0; i < 200; i++) begin
            int          kind, ackn;
            logic        wr, rd;
            logic [31:0] addr;
            kind = $urandom_range(0, 7);
            wr   = (kind >= 4);
            rd   = (kind >= 1 && kind <= 3) || (kind == 7);
            addr = $urandom;
            if ($urandom_range(0, 99) < 85) addr[1:0] = 2'b00;
            if ($urandom_range(0, 1) == 1) ackn = $urandom_range(1, 4);
            else ackn = $urandom_range(1, TO + 3);
            run_instr(wr, rd, addr, $urandom, $urandom, ackn, 1'b1);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
